// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder: defaults, limits,
// FSM state encoding and a small decode helper.
package data_sram_resp_pkg;

  // Default word-index width (depth = 2^12 words of 32 bits).
  localparam int DATA_SRAM_ADDR_W = 12;

  // Largest supported wait-state count; the wait counter is 4 bits wide.
  localparam int DATA_SRAM_WAIT_MAX = 15;

  // Responder FSM states used when wait states are configured.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // A request with any byte lane enabled is a store; all-zero is a load.
  function automatic logic is_write(input logic [3:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data-SRAM bus between the EX/MEM stages (master) and the responder (slave).
interface data_sram_resp_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  // Pipeline side: issues requests, consumes read data and stall.
  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq
  );

  // Memory side: services requests, returns read data and stall.
  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq
  );

endinterface

// File: rtl/data_sram_resp_sram_bytewise.sv
// Single-port synchronous RAM, 2^ADDR_W x 32, with per-byte write enables
// and a registered read port. Each byte lane is its own array so every lane
// maps cleanly onto block RAM with no shared write port.
module data_sram_resp_sram_bytewise
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = DATA_SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic rd_en;
  assign rd_en = en && !is_write(wen);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      // Byte-lane write: only lanes with their enable set are touched.
      always_ff @(posedge clk) begin
        if (en && wen[gi]) begin
          mem[idx] <= wdata[8*gi +: 8];
        end
      end

      // Registered read: updates only on a completed load, holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg <= '0;
        end else if (rd_en) begin
          rd_reg <= mem[idx];
        end
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: wraps the byte-writable RAM with an optional fixed
// wait-state sequencer that latches the request and raises stallreq while
// the access is pending. With zero wait states requests go straight to RAM.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W      = DATA_SRAM_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  data_sram_resp_if.slave bus
);

  // Out-of-range wait counts saturate at the counter's capacity.
  localparam int WAIT_EFF = (WAIT_CYCLES > DATA_SRAM_WAIT_MAX) ? DATA_SRAM_WAIT_MAX : WAIT_CYCLES;

  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram_wdata;
  logic [ADDR_W-1:0] req_idx;

  // Word addressing: byte offset and bits above the array alias away.
  assign req_idx = bus.data_sram_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.data_sram_addr[1:0], bus.data_sram_addr[31:ADDR_W+2]};

  generate
    if (WAIT_EFF == 0) begin : g_direct
      // Single-cycle path: the live request drives the RAM; reset blocks writes.
      assign ram_en      = bus.data_sram_en & ~rst;
      assign ram_wen     = bus.data_sram_wen;
      assign ram_idx     = req_idx;
      assign ram_wdata   = bus.data_sram_wdata;
      assign bus.stallreq = 1'b0;
    end else begin : g_wait
      state_t            state_reg;
      state_t            state_next;
      logic [3:0]        cnt_reg;
      logic [3:0]        cnt_next;
      logic              accept;
      logic              stall;
      logic [3:0]        lat_wen_reg;
      logic [ADDR_W-1:0] lat_idx_reg;
      logic [31:0]       lat_wdata_reg;

      // State and wait-counter register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Request latch: captured in the accept cycle, replayed in DONE.
      always_ff @(posedge clk) begin
        if (rst) begin
          lat_wen_reg   <= '0;
          lat_idx_reg   <= '0;
          lat_wdata_reg <= '0;
        end else if (accept) begin
          lat_wen_reg   <= bus.data_sram_wen;
          lat_idx_reg   <= req_idx;
          lat_wdata_reg <= bus.data_sram_wdata;
        end
      end

      // Next-state, counter and stall decode. The counter holds the number
      // of stalled cycles still to come after the current one; DONE follows
      // the cycle in which it reaches zero, so stallreq spans exactly
      // WAIT_CYCLES cycles starting with the accept cycle.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        stall      = 1'b0;
        case (state_reg)
          IDLE: begin
            if (bus.data_sram_en) begin
              accept     = 1'b1;
              stall      = 1'b1;
              cnt_next   = 4'(WAIT_EFF - 1);
              state_next = (WAIT_EFF == 1) ? DONE : WAIT;
            end
          end
          WAIT: begin
            stall    = 1'b1;
            cnt_next = cnt_reg - 4'd1;
            if (cnt_next == 4'd0) begin
              state_next = DONE;
            end
          end
          DONE: begin
            state_next = IDLE;
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      // The latched access is performed in DONE unless reset drops it.
      assign ram_en       = (state_reg == DONE) & ~rst;
      assign ram_wen      = lat_wen_reg;
      assign ram_idx      = lat_idx_reg;
      assign ram_wdata    = lat_wdata_reg;
      assign bus.stallreq = stall;
    end
  endgenerate

  data_sram_resp_sram_bytewise #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .wen   (ram_wen),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (bus.data_sram_rdata)
  );

endmodule
